// File: rtl/score_seg7_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner for the packed-BCD score.
// Frame-synchronous shadow capture, leading-zero blanking, dash for invalid digits, blink mode.
module score_seg7_scanner #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLANK_LEADING = 1,
  parameter int unsigned BLINK_FRAMES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          hidden_q, hidden_d;
  logic          frame_tick_q, frame_tick_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          slot_tick_c;
  logic          frame_end_c;
  logic [3:0]    digit_c;
  logic          lead_blank_c;
  logic          dark_c;
  logic [3:0]    zero_c;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      fcnt_q       <= '0;
      hidden_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      fcnt_q       <= fcnt_d;
      hidden_q     <= hidden_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    fcnt_d       = fcnt_q;
    hidden_d     = hidden_q;
    frame_tick_d = 1'b0;
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    digit_c      = 4'h0;
    lead_blank_c = 1'b0;

    slot_tick_c = (presc_q == PW'(REFRESH_DIV - 1));
    frame_end_c = slot_tick_c && (idx_q == 2'd3);

    presc_d = slot_tick_c ? '0 : presc_q + PW'(1);
    if (slot_tick_c) idx_d = idx_q + 2'd1;
    frame_tick_d = frame_end_c;
    if (frame_end_c) shadow_d = bcd;

    // Phase flips on the same edge the new frame starts so a frame is never half lit.
    if (!blink_en) begin
      fcnt_d   = '0;
      hidden_d = 1'b0;
    end else if (frame_end_c) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d   = '0;
        hidden_d = ~hidden_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    zero_c[0] = (shadow_q[3:0]   == 4'h0);
    zero_c[1] = (shadow_q[7:4]   == 4'h0);
    zero_c[2] = (shadow_q[11:8]  == 4'h0);
    zero_c[3] = (shadow_q[15:12] == 4'h0);

    case (idx_q)
      2'd0: begin
        digit_c      = shadow_q[3:0];
        lead_blank_c = 1'b0;
      end
      2'd1: begin
        digit_c      = shadow_q[7:4];
        lead_blank_c = zero_c[3] & zero_c[2] & zero_c[1];
      end
      2'd2: begin
        digit_c      = shadow_q[11:8];
        lead_blank_c = zero_c[3] & zero_c[2];
      end
      default: begin
        digit_c      = shadow_q[15:12];
        lead_blank_c = zero_c[3];
      end
    endcase

    // Gating hidden with blink_en lets the display return the clock after blink_en drops.
    dark_c = (hidden_q & blink_en) | ((BLANK_LEADING != 0) & lead_blank_c);
    if (!dark_c) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = encode(digit_c);
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_score_seg7_scanner.sv
// Scoreboard bench for score_seg7_scanner: stimulus pushes per-slot expectations at each frame
// start, a monitor pops and compares them in the middle of every display slot.
module tb_score_seg7_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        blink_en;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic        frame_tick_a, frame_tick_b;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] an_a;
    logic [6:0] seg_a;
    logic [3:0] an_b;
    logic [6:0] seg_b;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [15:0] AN_ALL  = 16'h7BDE;
  localparam logic [15:0] AN_DARK = 16'hFFFF;
  localparam logic [27:0] SEG_DARK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};

  score_seg7_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .bcd(bcd), .blink_en(blink_en),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(frame_tick_a)
  );

  score_seg7_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(0), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .bcd(bcd), .blink_en(blink_en),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(frame_tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot k of each argument sits at bits [4k +: 4] / [7k +: 7].
  task automatic push_frame(input logic [15:0] ea, input logic [27:0] sa,
                            input logic [15:0] eb, input logic [27:0] sb);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an_a  = ea[4*k +: 4];
      e.seg_a = sa[7*k +: 7];
      e.an_b  = eb[4*k +: 4];
      e.seg_b = sb[7*k +: 7];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_tick_a) found = 1'b1;
    end
    if (!found) chk("frame_tick_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: slot k outputs are stable on negedges N0+1+4k .. N0+4+4k after the frame_tick negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && frame_tick_a) begin
        for (int s = 0; s < 4; s++) begin
          repeat ((s == 0) ? 2 : 4) @(negedge clk);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d_an_a", s),  32'(an_a),  32'(e.an_a));
            chk($sformatf("slot%0d_seg_a", s), 32'(seg_a), 32'(e.seg_a));
            chk($sformatf("slot%0d_an_b", s),  32'(an_b),  32'(e.an_b));
            chk($sformatf("slot%0d_seg_b", s), 32'(seg_b), 32'(e.seg_b));
            chk("dp_off", 32'({dp_a, dp_b}), 32'd3);
            chk("an_onehot", 32'($countones(~an_a) <= 1), 32'd1);
          end
        end
      end
    end
  end

  // Frame period: 4 slots * 4 clocks.
  initial begin
    int  gap;
    bit  valid;
    gap = 0;
    valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        valid = 1'b0;
        gap = 0;
      end else begin
        gap++;
        if (frame_tick_a) begin
          if (valid) chk("frame_period", 32'(gap), 32'd16);
          gap = 0;
          valid = 1'b1;
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bcd      = 16'h0000;
    blink_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_dp", 32'(dp_a), 32'd1);
    chk("rst_ft", 32'(frame_tick_a), 32'd0);
    rst = 1'b0;
    bcd = 16'h1234;
    @(negedge clk);
    chk("post_rst_an", 32'(an_a), 32'hE);
    chk("post_rst_seg", 32'(seg_a), 32'h40);

    // Basic scan of 1234 for two frames.
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);

    // Asynchronous reset mid-frame.
    wait_frame();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an_a), 32'hF);
    chk("async_rst_seg", 32'(seg_a), 32'h7F);
    chk("async_rst_dp", 32'(dp_a), 32'd1);
    chk("async_rst_ft", 32'(frame_tick_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_slot0_an", 32'(an_b), 32'hE);
    chk("restart_slot0_seg", 32'(seg_b), 32'h40);
    repeat (4) @(negedge clk);
    chk("restart_slot1_an_b", 32'(an_b), 32'hD);
    chk("restart_slot1_an_a", 32'(an_a), 32'hF);

    // Leading-zero blanking.
    bcd = 16'h0007;
    wait_frame();
    push_frame(16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h78}, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h78});
    bcd = 16'h0000;
    wait_frame();
    push_frame(16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});

    // Invalid digit renders as dash and counts as nonzero.
    bcd = 16'h00A0;
    wait_frame();
    push_frame(16'hFFDE, {7'h7F, 7'h7F, 7'h3F, 7'h40}, AN_ALL, {7'h40, 7'h40, 7'h3F, 7'h40});

    // Mid-frame bcd change must not tear the current frame.
    bcd = 16'h1234;
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    repeat (6) @(negedge clk);
    bcd = 16'h5678;
    wait_frame();
    push_frame(AN_ALL, {7'h12, 7'h02, 7'h78, 7'h00}, AN_ALL, {7'h12, 7'h02, 7'h78, 7'h00});

    // Blink: lit, lit, dark, dark, lit, lit, dark ...
    bcd = 16'h1234;
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    blink_en = 1'b1;
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    wait_frame();
    push_frame(AN_DARK, SEG_DARK, AN_DARK, SEG_DARK);
    wait_frame();
    push_frame(AN_DARK, SEG_DARK, AN_DARK, SEG_DARK);
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    wait_frame();
    push_frame({4'h7, 4'hB, 4'hD, 4'hF}, {7'h79, 7'h24, 7'h30, 7'h7F},
               {4'h7, 4'hB, 4'hD, 4'hF}, {7'h79, 7'h24, 7'h30, 7'h7F});
    repeat (3) @(negedge clk);
    blink_en = 1'b0;
    @(negedge clk);
    chk("unblink_an", 32'(an_a), 32'hE);
    chk("unblink_seg", 32'(seg_a), 32'h19);
    wait_frame();
    push_frame(AN_ALL, SEG_1234, AN_ALL, SEG_1234);
    wait_frame();
    repeat (4) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
